mpu_ctlif_multi: RTL and testbench
==================================

Name: mpu_ctlif_multi

Overview:
- Multi-channel successor to the single-MPU control interface: one CSR slave that starts, stops, watches and services NCH independent MPU cores.
- Runs entirely in the sys_clk domain; the cores share that clock.
- Adds three things per channel:
  - a watchdog timeout that aborts a runaway core;
  - a saturating run-cycle counter;
  - a per-channel IRQ vector plus a global pending summary register.

Parameters:
- csr_addr, 4'h0: CSR page matched against csr_a[13:10].
- NCH, 4: number of MPU channels, 1..16.
- UDW, 64: user_data width per channel, 1..64. CSR reads zero-extend it to 64 bits.

Ports:
- sys_clk  in  1  system clock; all logic is synchronous to it.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- csr_a  in  14  CSR address.
- csr_we  in  1  CSR write strobe.
- csr_di  in  32  CSR write data.
- csr_do  out  32  CSR read data, registered.
- mpu_en  out  NCH  per-channel core enable.
- mpu_rst  out  NCH  per-channel core reset pulse, active-high.
- user_irq  in  NCH  per-channel core interrupt request.
- user_data  in  NCH*UDW  per-channel data; channel i occupies [i*UDW +: UDW].
- error  in  NCH  per-channel core error.
- irq_vec  out  NCH  per-channel interrupt.
- irq  out  1  OR of irq_vec.

Behaviour:

Reset:
- While sys_rst_n=0, every register clears immediately: csr_do, mpu_en, mpu_rst, all events, irq_en, start, timeout, cyc, udata.
- Every channel goes to IDLE, so irq and irq_vec read 0.

CSR decode:
- The block is selected when csr_a[13:10]==csr_addr.
- Channel index ch=csr_a[9:3]; register index r=csr_a[2:0].
- If ch>=NCH and the address is not 0x3FF, reads return 0 and writes are ignored.
- Read latency is 1 cycle. csr_do returns 0 in any cycle where the block is not selected.

Per-channel registers:
- r=0 STAT: bit0 end, bit1 error, bit2 user_irq, bit3 timeout. Write-1-to-clear.
- r=1 CTRL: bit0 irq_en, bit1 start.
- r=2 UDATA_LO: udata[31:0], read-only.
- r=3 UDATA_HI: udata[63:32], read-only.
- r=4 TIMEOUT: 32-bit read/write. 0 disables the watchdog.
- r=5 CYC: cycles spent in RUN since the last IDLE->RESET. 32-bit, saturating, read-only.
- 0x3FF PEND: read-only, {(32-NCH) zeros, irq_vec}.

Write restrictions:
- STAT clears take effect only in IDLE or WAIT.
- irq_en and TIMEOUT writes take effect only in IDLE.
- start is writable in every state.

Interrupts:
- irq_vec[i] = irq_en & (OR of STAT[3:0]) for channel i.

Per-channel FSM (states in shared package):
- IDLE: if start=1, go to RESET with mpu_rst=1, cyc=0.
- RESET (exactly 1 cycle): go to RUN with mpu_rst=0, mpu_en=1.
- RUN: cyc increments each cycle. Exit conditions, evaluated in this priority order:
  1. start=0: go to IDLE with en=0. No event is raised.
  2. error=1: go to IDLE; set error event, clear start.
  3. TIMEOUT!=0 and cyc+1==TIMEOUT: go to IDLE; set timeout event, clear start.
  4. user_irq=1 and user_data==0: go to IDLE; set end event, clear start.
  5. user_irq=1: go to WAIT; latch udata, set user_irq event.
  - Every RUN->IDLE and RUN->WAIT exit drives en=0.
- WAIT: cyc holds.
  - If the user_irq event has been cleared: go to RUN with en=1, udata=0.
  - Otherwise, if start=0: go to IDLE with udata=0.

Boundary rules:
- A hardware event set and a software W1C on the same bit in the same cycle: set wins.
- An FSM clear of start and a software write of start=1 in the same cycle: the FSM clear wins.
- Writing start=1 while in RUN or WAIT has no effect on the FSM.
- TIMEOUT=1 aborts on the first RUN cycle.
- cyc saturates at 0xFFFFFFFF. The watchdog still fires if TIMEOUT equals that value.
- Events from different channels in the same cycle are independent. Channels share no state.

Decomposition:
- Package mpu_pkg holds:
  - state encodings: IDLE, RESET, RUN, WAIT;
  - register offsets: STAT, CTRL, UDATA_LO, UDATA_HI, TIMEOUT, CYC;
  - the PEND address 0x3FF;
  - STAT bit positions.
- Sub-module mpu_ctlif_chan holds one channel: its FSM, event flags, TIMEOUT, cyc and udata.
  - Its inputs are decoded write strobes plus csr_di; it outputs a 32-bit read vector per register.
- The top level instantiates NCH copies of mpu_ctlif_chan in a generate loop and contains the CSR decode, read mux and irq OR.

Test Plan:
- Reset mid-RUN: on channel 0 in RUN, pulse sys_rst_n low asynchronously (not on a clock edge) → mpu_en=0 and irq=0 immediately; CTRL reads 0.
- Start/end: ch1 CTRL=0x3; after 20 cycles assert user_irq=1 with data=0 → RESET lasts 1 cycle; en is high 20 cycles then falls; STAT=0x1; irq_vec=0x2; PEND=0x2; CTRL reads 0x1.
- User IRQ round trip: ch2 runs, user_data=0xDEADBEEF_00000001 with user_irq=1 → WAIT; UDATA_HI=0xDEADBEEF, UDATA_LO=0x1. Then write STAT=0x4 → RUN on the next cycle with en=1; UDATA reads 0.
- Watchdog: ch0 TIMEOUT=100, start → en is high for exactly 100 cycles; STAT=0x8; CYC=100. With TIMEOUT=0 and 200 cycles of running, no abort occurs.
- Priority: error=1 and user_irq=1 (data 0) on the same RUN cycle → STAT=0x2 only. Software writes start=0 in the same cycle as error=1 → IDLE, STAT=0.
- Channel isolation and decode: ch3 errors while ch1 is running → ch1 en stays 1, PEND=0x8. Reads at ch index 5 with NCH=4 return 0.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared definitions for the multi-channel MPU control interface.
// Holds the per-channel FSM state encoding, the CSR register offsets inside a
// channel window, the global PEND address, the STAT/CTRL bit positions and the
// read-back bundle that each channel presents to the top-level read mux.
package mpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Register offsets within one channel window (csr_a[2:0]).
  localparam logic [2:0] REG_STAT     = 3'd0;
  localparam logic [2:0] REG_CTRL     = 3'd1;
  localparam logic [2:0] REG_UDATA_LO = 3'd2;
  localparam logic [2:0] REG_UDATA_HI = 3'd3;
  localparam logic [2:0] REG_TIMEOUT  = 3'd4;
  localparam logic [2:0] REG_CYC      = 3'd5;

  // Global pending-summary address (csr_a[9:0]).
  localparam logic [9:0] PEND_ADDR = 10'h3FF;

  // STAT bit positions.
  localparam int STAT_END  = 0;
  localparam int STAT_ERR  = 1;
  localparam int STAT_UIRQ = 2;
  localparam int STAT_TMO  = 3;

  // CTRL bit positions.
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_START  = 1;

  // Read-back view of one channel, already widened to 32 bits per register.
  typedef struct packed {
    logic [31:0] stat;
    logic [31:0] ctrl;
    logic [31:0] udata_lo;
    logic [31:0] udata_hi;
    logic [31:0] timeout;
    logic [31:0] cyc;
  } chan_rd_t;

endpackage

// File: rtl/mpu_ctlif_chan.sv
// One MPU channel: start/stop FSM, event flags, watchdog, saturating run-cycle
// counter and user-data latch.
// Ports:
//   sys_clk, sys_rst_n          clock, async active-low reset
//   stat_we/ctrl_we/timeout_we  decoded CSR write strobes for this channel
//   wdata                       CSR write data
//   user_irq/user_data/error    core status inputs
//   mpu_en, mpu_rst             core enable and 1-cycle reset pulse
//   irq                         irq_en AND any pending event
//   rd                          32-bit read view of every channel register
module mpu_ctlif_chan
  import mpu_pkg::*;
#(
  parameter int UDW = 64
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           stat_we,
  input  logic           ctrl_we,
  input  logic           timeout_we,
  input  logic [31:0]    wdata,
  input  logic           user_irq,
  input  logic [UDW-1:0] user_data,
  input  logic           error,
  output logic           mpu_en,
  output logic           mpu_rst,
  output logic           irq,
  output chan_rd_t       rd
);

  state_e         state_q, state_d;
  logic [3:0]     ev_q, ev_d;
  logic           irq_en_q, irq_en_d;
  logic           start_q, start_d;
  logic [31:0]    timeout_q, timeout_d;
  logic [31:0]    cyc_q, cyc_d;
  logic [UDW-1:0] udata_q, udata_d;
  logic           en_q, en_d;
  logic           rst_q, rst_d;

  logic           start_eff;
  logic [3:0]     ev_set, ev_clr;
  logic [63:0]    udata_ext;

  always_comb begin
    // NOTE: every combinational output starts from a default so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    irq_en_d  = irq_en_q;
    timeout_d = timeout_q;
    cyc_d     = cyc_q;
    udata_d   = udata_q;
    en_d      = en_q;
    rst_d     = rst_q;
    ev_set    = '0;

    // A start written this cycle is seen by the FSM immediately, so a
    // software stop outranks a same-cycle hardware exit.
    start_eff = ctrl_we ? wdata[CTRL_START] : start_q;
    start_d   = start_eff;

    if (ctrl_we && state_q == ST_IDLE)    irq_en_d  = wdata[CTRL_IRQ_EN];
    if (timeout_we && state_q == ST_IDLE) timeout_d = wdata;
    ev_clr = (stat_we && (state_q == ST_IDLE || state_q == ST_WAIT)) ? wdata[3:0] : '0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_eff) begin
          state_d = ST_RESET;
          rst_d   = 1'b1;
          cyc_d   = '0;
        end
      end
      ST_RESET: begin
        state_d = ST_RUN;
        rst_d   = 1'b0;
        en_d    = 1'b1;
      end
      ST_RUN: begin
        cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
        if (!start_eff) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
        end else if (error) begin
          state_d          = ST_IDLE;
          en_d             = 1'b0;
          ev_set[STAT_ERR] = 1'b1;
          start_d          = 1'b0;
        end else if (timeout_q != '0 && (cyc_q + 32'd1) == timeout_q) begin
          state_d          = ST_IDLE;
          en_d             = 1'b0;
          ev_set[STAT_TMO] = 1'b1;
          start_d          = 1'b0;
        end else if (user_irq && user_data == '0) begin
          state_d          = ST_IDLE;
          en_d             = 1'b0;
          ev_set[STAT_END] = 1'b1;
          start_d          = 1'b0;
        end else if (user_irq) begin
          state_d           = ST_WAIT;
          en_d              = 1'b0;
          udata_d           = user_data;
          ev_set[STAT_UIRQ] = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!ev_q[STAT_UIRQ]) begin
          state_d = ST_RUN;
          en_d    = 1'b1;
          udata_d = '0;
        end else if (!start_eff) begin
          state_d = ST_IDLE;
          udata_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Hardware set wins over a same-cycle software clear.
    ev_d = (ev_q & ~ev_clr) | ev_set;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      ev_q      <= '0;
      irq_en_q  <= 1'b0;
      start_q   <= 1'b0;
      timeout_q <= '0;
      cyc_q     <= '0;
      udata_q   <= '0;
      en_q      <= 1'b0;
      rst_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ev_q      <= ev_d;
      irq_en_q  <= irq_en_d;
      start_q   <= start_d;
      timeout_q <= timeout_d;
      cyc_q     <= cyc_d;
      udata_q   <= udata_d;
      en_q      <= en_d;
      rst_q     <= rst_d;
    end
  end

  assign mpu_en    = en_q;
  assign mpu_rst   = rst_q;
  assign irq       = irq_en_q & (|ev_q);
  assign udata_ext = 64'(udata_q);

  assign rd.stat     = 32'(ev_q);
  assign rd.ctrl     = {30'd0, start_q, irq_en_q};
  assign rd.udata_lo = udata_ext[31:0];
  assign rd.udata_hi = udata_ext[63:32];
  assign rd.timeout  = timeout_q;
  assign rd.cyc      = cyc_q;

endmodule

// File: rtl/mpu_ctlif_multi.sv
// Multi-channel MPU control interface: one CSR slave driving NCH independent
// MPU channels. Decodes csr_a into channel/register, fans write strobes out to
// the channels, muxes the registered read data and ORs the channel IRQs.
// Ports:
//   sys_clk, sys_rst_n           clock, async active-low reset
//   csr_a/csr_we/csr_di/csr_do   CSR bus (csr_do registered, 1-cycle latency)
//   mpu_en, mpu_rst              per-channel core enable / reset pulse
//   user_irq, user_data, error   per-channel core status
//   irq_vec, irq                 per-channel interrupt and their OR
module mpu_ctlif_multi
  import mpu_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int         NCH      = 4,
  parameter int         UDW      = 64
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [13:0]        csr_a,
  input  logic               csr_we,
  input  logic [31:0]        csr_di,
  output logic [31:0]        csr_do,
  output logic [NCH-1:0]     mpu_en,
  output logic [NCH-1:0]     mpu_rst,
  input  logic [NCH-1:0]     user_irq,
  input  logic [NCH*UDW-1:0] user_data,
  input  logic [NCH-1:0]     error,
  output logic [NCH-1:0]     irq_vec,
  output logic               irq
);

  logic        sel;
  logic        is_pend;
  logic [6:0]  ch;
  logic [2:0]  r;
  logic [31:0] csr_do_q, csr_do_d;
  chan_rd_t    rd [NCH];

  assign sel     = (csr_a[13:10] == csr_addr);
  assign ch      = csr_a[9:3];
  assign r       = csr_a[2:0];
  assign is_pend = (csr_a[9:0] == PEND_ADDR);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic hit;
    // Channel indices stop at 16, so the PEND address never aliases a channel.
    assign hit = sel && csr_we && (ch == 7'(i));

    mpu_ctlif_chan #(.UDW(UDW)) u_chan (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .stat_we    (hit && r == REG_STAT),
      .ctrl_we    (hit && r == REG_CTRL),
      .timeout_we (hit && r == REG_TIMEOUT),
      .wdata      (csr_di),
      .user_irq   (user_irq[i]),
      .user_data  (user_data[i*UDW +: UDW]),
      .error      (error[i]),
      .mpu_en     (mpu_en[i]),
      .mpu_rst    (mpu_rst[i]),
      .irq        (irq_vec[i]),
      .rd         (rd[i])
    );
  end

  always_comb begin
    csr_do_d = '0;
    if (sel) begin
      if (is_pend) begin
        csr_do_d = 32'(irq_vec);
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (ch == 7'(i)) begin
            case (r)
              REG_STAT:     csr_do_d = rd[i].stat;
              REG_CTRL:     csr_do_d = rd[i].ctrl;
              REG_UDATA_LO: csr_do_d = rd[i].udata_lo;
              REG_UDATA_HI: csr_do_d = rd[i].udata_hi;
              REG_TIMEOUT:  csr_do_d = rd[i].timeout;
              REG_CYC:      csr_do_d = rd[i].cyc;
              default:      csr_do_d = '0;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) csr_do_q <= '0;
    else            csr_do_q <= csr_do_d;
  end

  assign csr_do = csr_do_q;
  assign irq    = |irq_vec;

endmodule

// File: tb/tb_mpu_ctlif_multi.sv
// Directed bench for mpu_ctlif_multi (NCH=4, UDW=64, csr_addr=0).
// All CSR tasks are entered on a falling edge and return on a falling edge.
module tb_mpu_ctlif_multi;

  localparam int NCH = 4;
  localparam int UDW = 64;
  localparam logic [13:0] IDLE_A = 14'h3C00;  // page 0xF: block not selected

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic [13:0]        csr_a = IDLE_A;
  logic               csr_we = 1'b0;
  logic [31:0]        csr_di = '0;
  logic [31:0]        csr_do;
  logic [NCH-1:0]     mpu_en, mpu_rst, irq_vec;
  logic [NCH-1:0]     user_irq = '0;
  logic [NCH*UDW-1:0] user_data = '0;
  logic [NCH-1:0]     error = '0;
  logic               irq;

  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt  [NCH];
  int rst_cnt [NCH];
  logic [31:0] rdat;

  mpu_ctlif_multi #(.csr_addr(4'h0), .NCH(NCH), .UDW(UDW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_di    (csr_di),
    .csr_do    (csr_do),
    .mpu_en    (mpu_en),
    .mpu_rst   (mpu_rst),
    .user_irq  (user_irq),
    .user_data (user_data),
    .error     (error),
    .irq_vec   (irq_vec),
    .irq       (irq)
  );

  always #5 sys_clk = ~sys_clk;

  // Count rising edges on which each enable / reset pulse was high.
  always @(posedge sys_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (mpu_en[i])  en_cnt[i]++;
      if (mpu_rst[i]) rst_cnt[i]++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [13:0] ra(input int ch, input int r);
    return {4'h0, 7'(ch), 3'(r)};
  endfunction

  task automatic csr_wr(input int ch, input int r, input logic [31:0] d);
    csr_a = ra(ch, r); csr_we = 1'b1; csr_di = d;
    @(negedge sys_clk);
    csr_we = 1'b0; csr_a = IDLE_A; csr_di = '0;
  endtask

  task automatic csr_rd(input int ch, input int r, output logic [31:0] d);
    csr_a = ra(ch, r);
    @(negedge sys_clk);
    d = csr_do;
    csr_a = IDLE_A;
  endtask

  task automatic wait_en(input string tag, input int ch, input logic val, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge sys_clk);
      if (mpu_en[ch] === val) break;
    end
    check(tag, mpu_en[ch], val);
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin en_cnt[i] = 0; rst_cnt[i] = 0; end

    // Reset state
    #12;
    check("rst_en", mpu_en, 4'h0);
    check("rst_rst", mpu_rst, 4'h0);
    check("rst_irqvec", irq_vec, 4'h0);
    check("rst_irq", irq, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("desel_do", csr_do, 32'h0);

    // Start/end on channel 1
    rst_cnt[1] = 0; en_cnt[1] = 0;
    csr_wr(1, 1, 32'h3);
    check("a_rst_pulse", mpu_rst[1], 1'b1);
    wait_en("a_en_up", 1, 1'b1, 10);
    repeat (19) @(negedge sys_clk);
    user_irq[1] = 1'b1;
    @(negedge sys_clk);
    user_irq[1] = 1'b0;
    check("a_en_down", mpu_en[1], 1'b0);
    check("a_en_cycles", en_cnt[1], 20);
    check("a_rst_cycles", rst_cnt[1], 1);
    csr_rd(1, 0, rdat); check("a_stat", rdat, 32'h1);
    check("a_irqvec", irq_vec, 4'h2);
    check("a_irq", irq, 1'b1);
    csr_rd(127, 7, rdat); check("a_pend", rdat, 32'h2);
    csr_rd(1, 1, rdat); check("a_ctrl", rdat, 32'h1);
    csr_rd(1, 5, rdat); check("a_cyc", rdat, 32'd20);
    csr_wr(1, 0, 32'h1);
    check("a_clr_irqvec", irq_vec, 4'h0);

    // User IRQ round trip on channel 2
    csr_wr(2, 1, 32'h2);
    wait_en("b_en_up", 2, 1'b1, 10);
    user_data[2*UDW +: UDW] = 64'hDEADBEEF_00000001;
    user_irq[2] = 1'b1;
    @(negedge sys_clk);
    user_irq[2] = 1'b0;
    check("b_en_wait", mpu_en[2], 1'b0);
    csr_rd(2, 3, rdat); check("b_ud_hi", rdat, 32'hDEADBEEF);
    csr_rd(2, 2, rdat); check("b_ud_lo", rdat, 32'h1);
    csr_rd(2, 0, rdat); check("b_stat", rdat, 32'h4);
    check("b_no_irq", irq_vec[2], 1'b0);
    csr_wr(2, 0, 32'h4);
    @(negedge sys_clk);
    check("b_en_resume", mpu_en[2], 1'b1);
    csr_rd(2, 2, rdat); check("b_ud_lo_clr", rdat, 32'h0);
    csr_rd(2, 3, rdat); check("b_ud_hi_clr", rdat, 32'h0);
    csr_wr(2, 1, 32'h0);
    check("b_stop", mpu_en[2], 1'b0);
    user_data = '0;

    // Watchdog on channel 0
    csr_wr(0, 4, 32'd100);
    en_cnt[0] = 0;
    csr_wr(0, 1, 32'h2);
    wait_en("c_en_up", 0, 1'b1, 10);
    wait_en("c_en_down", 0, 1'b0, 200);
    check("c_en_cycles", en_cnt[0], 100);
    csr_rd(0, 0, rdat); check("c_stat", rdat, 32'h8);
    csr_rd(0, 5, rdat); check("c_cyc", rdat, 32'd100);
    csr_rd(0, 1, rdat); check("c_ctrl", rdat, 32'h0);
    csr_wr(0, 0, 32'h8);
    // TIMEOUT=1 aborts on the first RUN cycle
    csr_wr(0, 4, 32'd1);
    en_cnt[0] = 0;
    csr_wr(0, 1, 32'h2);
    wait_en("c1_en_up", 0, 1'b1, 10);
    wait_en("c1_en_down", 0, 1'b0, 10);
    check("c1_en_cycles", en_cnt[0], 1);
    csr_rd(0, 0, rdat); check("c1_stat", rdat, 32'h8);
    csr_wr(0, 0, 32'h8);
    // TIMEOUT=0 never aborts
    csr_wr(0, 4, 32'd0);
    csr_wr(0, 1, 32'h2);
    repeat (200) @(negedge sys_clk);
    check("c0_en_still", mpu_en[0], 1'b1);
    csr_rd(0, 5, rdat); check("c0_cyc", rdat, 32'd199);
    csr_rd(0, 0, rdat); check("c0_stat", rdat, 32'h0);
    csr_wr(0, 1, 32'h0);
    check("c0_stop", mpu_en[0], 1'b0);

    // Priority on channel 3
    csr_wr(3, 1, 32'h2);
    wait_en("d_en_up", 3, 1'b1, 10);
    error[3] = 1'b1; user_irq[3] = 1'b1;
    @(negedge sys_clk);
    error[3] = 1'b0; user_irq[3] = 1'b0;
    check("d_en_down", mpu_en[3], 1'b0);
    csr_rd(3, 0, rdat); check("d_stat_err", rdat, 32'h2);
    csr_wr(3, 0, 32'h2);
    // software stop in the same cycle as error: no event
    csr_wr(3, 1, 32'h2);
    wait_en("d2_en_up", 3, 1'b1, 10);
    error[3] = 1'b1;
    csr_wr(3, 1, 32'h0);
    error[3] = 1'b0;
    check("d2_en_down", mpu_en[3], 1'b0);
    csr_rd(3, 0, rdat); check("d2_stat", rdat, 32'h0);
    // start=1 written in the same cycle the FSM clears it: clear wins
    csr_wr(3, 1, 32'h2);
    wait_en("d3_en_up", 3, 1'b1, 10);
    error[3] = 1'b1;
    csr_wr(3, 1, 32'h2);
    error[3] = 1'b0;
    csr_rd(3, 1, rdat); check("d3_ctrl", rdat, 32'h0);
    csr_rd(3, 0, rdat); check("d3_stat", rdat, 32'h2);
    csr_wr(3, 0, 32'h2);

    // Channel isolation and decode
    csr_wr(3, 1, 32'h1);
    csr_wr(1, 1, 32'h3);
    csr_wr(0, 1, 32'h2);
    csr_wr(3, 1, 32'h3);
    wait_en("e_en3_up", 3, 1'b1, 10);
    csr_wr(1, 4, 32'd5);
    csr_rd(1, 4, rdat); check("e_tmo_locked", rdat, 32'h0);
    error[3] = 1'b1;
    @(negedge sys_clk);
    error[3] = 1'b0;
    check("e_en1", mpu_en[1], 1'b1);
    check("e_en3", mpu_en[3], 1'b0);
    check("e_irqvec", irq_vec, 4'h8);
    check("e_irq", irq, 1'b1);
    csr_rd(127, 7, rdat); check("e_pend", rdat, 32'h8);
    csr_wr(5, 1, 32'h3);
    csr_rd(5, 1, rdat); check("e_ch5_ctrl", rdat, 32'h0);
    csr_rd(5, 0, rdat); check("e_ch5_stat", rdat, 32'h0);
    csr_rd(1, 6, rdat); check("e_r6", rdat, 32'h0);
    check("e_en0", mpu_en[0], 1'b1);

    // Asynchronous reset while channels run
    #2 sys_rst_n = 1'b0;
    #1;
    check("r_en", mpu_en, 4'h0);
    check("r_irq", irq, 1'b0);
    check("r_irqvec", irq_vec, 4'h0);
    check("r_do", csr_do, 32'h0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    csr_rd(0, 1, rdat); check("r_ctrl0", rdat, 32'h0);
    csr_rd(3, 0, rdat); check("r_stat3", rdat, 32'h0);
    csr_rd(127, 7, rdat); check("r_pend", rdat, 32'h0);
    repeat (3) @(negedge sys_clk);
    check("r_en_stays", mpu_en, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
